// File: rtl/i2s_tx_10xe_defines.sv
// Shared definitions for the I2S transmit frame controller: default widths,
// divider width and the controller state encoding.
package i2s_tx_10xe_defines;

  localparam int SAMPLE_WIDTH_DEF = 24;
  localparam int SLOT_WIDTH_DEF   = 32;
  localparam int DIV_W            = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_e;

  // A programmed divider of 0 would never reach a terminal count, so it runs as 1.
  function automatic logic [DIV_W-1:0] div_floor1(input logic [DIV_W-1:0] div);
    return (div == '0) ? DIV_W'(1) : div;
  endfunction

endpackage

// File: rtl/i2s_tx_10xe_sclk_gen.sv
// SCLK generator: prescaler over aud_mclk that toggles sclk at each terminal
// count and flags the cycle whose closing edge makes sclk fall.
module i2s_tx_10xe_sclk_gen
  import i2s_tx_10xe_defines::*;
(
  input  logic             aud_mclk,
  input  logic             aud_mrst,
  input  logic             run,
  input  logic [DIV_W-1:0] div_eff,
  output logic             sclk,
  output logic             fall_stb
);

  logic [DIV_W-1:0] cnt_q;
  logic             terminal;

  assign terminal = (cnt_q == (div_eff - DIV_W'(1)));
  assign fall_stb = run && terminal && sclk;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge aud_mclk or posedge aud_mrst) begin
    if (aud_mrst) begin
      cnt_q <= '0;
      sclk  <= 1'b0;
    end else if (!run) begin
      cnt_q <= '0;
      sclk  <= 1'b0;
    end else if (terminal) begin
      cnt_q <= '0;
      sclk  <= ~sclk;
    end else begin
      cnt_q <= cnt_q + DIV_W'(1);
    end
  end

endmodule

// File: rtl/i2s_tx_10xe_frame_ctrl.sv
// I2S transmit frame controller: fetches one sample per channel slot and
// shifts it out MSB-first, stopping cleanly at a frame boundary.
module i2s_tx_10xe_frame_ctrl
  import i2s_tx_10xe_defines::*;
#(
  parameter int SAMPLE_WIDTH = SAMPLE_WIDTH_DEF,
  parameter int SLOT_WIDTH   = SLOT_WIDTH_DEF
) (
  input  logic                    aud_mclk,
  input  logic                    aud_mrst,
  input  logic                    enable,
  input  logic [DIV_W-1:0]        sclk_div,
  input  logic [SAMPLE_WIDTH-1:0] s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic                    irq_clr,
  output logic                    sclk_out,
  output logic                    lrclk_out,
  output logic                    sdata_0_out,
  output logic                    underflow_irq,
  output logic                    busy
);

  localparam int PW = (SLOT_WIDTH > 1) ? $clog2(SLOT_WIDTH) : 1;

  state_e                  state_q, state_d;
  logic [DIV_W-1:0]        div_eff_q;
  logic [PW-1:0]           p_q;
  logic [SAMPLE_WIDTH-1:0] shreg_q;
  logic                    fall_stb;
  logic                    slot_start;
  logic                    to_idle;
  logic                    fetch;

  i2s_tx_10xe_sclk_gen u_sclk_gen (
    .aud_mclk (aud_mclk),
    .aud_mrst (aud_mrst),
    .run      (state_q != ST_IDLE),
    .div_eff  (div_eff_q),
    .sclk     (sclk_out),
    .fall_stb (fall_stb)
  );

  // p_q holds the slot position that the next falling edge starts.
  assign slot_start = fall_stb && (p_q == '0);
  // A p=0 edge with lrclk high is the start of a left slot, i.e. a frame boundary.
  assign to_idle    = slot_start && (state_q == ST_STOP) && lrclk_out;

  // NOTE: every combinational output gets a default first so no path leaves a
  // signal unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    fetch   = 1'b0;
    unique case (state_q)
      ST_IDLE: if (enable) state_d = ST_RUN;
      ST_RUN:  if (!enable) state_d = ST_STOP;
      ST_STOP: if (to_idle) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (slot_start && !to_idle) fetch = 1'b1;
  end

  assign s_ready = fetch;
  assign busy    = (state_q != ST_IDLE);

  always_ff @(posedge aud_mclk or posedge aud_mrst) begin
    if (aud_mrst) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // NOTE: the shift register and slot counter are reset along with the outputs
  // so a reset mid-frame can never replay stale sample bits afterwards.
  always_ff @(posedge aud_mclk or posedge aud_mrst) begin
    if (aud_mrst) begin
      div_eff_q   <= DIV_W'(1);
      p_q         <= '0;
      shreg_q     <= '0;
      lrclk_out   <= 1'b1;
      sdata_0_out <= 1'b0;
    end else if (state_q == ST_IDLE) begin
      if (enable) div_eff_q <= div_floor1(sclk_div);
      p_q         <= '0;
      shreg_q     <= '0;
      lrclk_out   <= 1'b1;
      sdata_0_out <= 1'b0;
    end else if (fall_stb) begin
      if (to_idle || p_q == PW'(SLOT_WIDTH - 1)) p_q <= '0;
      else                                       p_q <= p_q + PW'(1);

      if (p_q == '0) begin
        sdata_0_out <= 1'b0;
        if (!to_idle) lrclk_out <= ~lrclk_out;
        shreg_q <= (fetch && s_valid) ? s_data : '0;
      end else if (p_q <= PW'(SAMPLE_WIDTH)) begin
        sdata_0_out <= shreg_q[SAMPLE_WIDTH-1];
        shreg_q     <= {shreg_q[SAMPLE_WIDTH-2:0], 1'b0};
      end else begin
        sdata_0_out <= 1'b0;
      end
    end
  end

  // A new underflow takes priority over a coincident clear.
  always_ff @(posedge aud_mclk or posedge aud_mrst) begin
    if (aud_mrst)                 underflow_irq <= 1'b0;
    else if (fetch && !s_valid)   underflow_irq <= 1'b1;
    else if (irq_clr)             underflow_irq <= 1'b0;
  end

endmodule

// File: tb/tb_i2s_tx_10xe_frame_ctrl.sv
// Directed bench for i2s_tx_10xe_frame_ctrl: a table of whole-frame vectors
// plus hand-written sequences for underflow, stop, divider and reset corners.
module tb_i2s_tx_10xe_frame_ctrl;

  logic        aud_mclk = 1'b0;
  logic        aud_mrst = 1'b1;
  logic        enable   = 1'b0;
  logic [7:0]  sclk_div = 8'd2;
  logic [23:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        irq_clr  = 1'b0;
  logic        sclk_out, lrclk_out, sdata_0_out, underflow_irq, busy;

  logic [23:0] cur_l = '0, cur_r = '0;
  logic        val_l = 1'b1, val_r = 1'b1;

  // The source presents the left sample while lrclk is still high (left fetch).
  assign s_data  = lrclk_out ? cur_l : cur_r;
  assign s_valid = lrclk_out ? val_l : val_r;

  i2s_tx_10xe_frame_ctrl dut (
    .aud_mclk      (aud_mclk),
    .aud_mrst      (aud_mrst),
    .enable        (enable),
    .sclk_div      (sclk_div),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .irq_clr       (irq_clr),
    .sclk_out      (sclk_out),
    .lrclk_out     (lrclk_out),
    .sdata_0_out   (sdata_0_out),
    .underflow_irq (underflow_irq),
    .busy          (busy)
  );

  always #5 aud_mclk = ~aud_mclk;

  typedef struct {
    string       name;
    logic [7:0]  div;
    logic [23:0] l, r;
    logic        vl, vr;
    int          exp_period, exp_frame;
    logic [23:0] exp_l, exp_r;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[5];

  int   n_vec = 0, n_fail = 0, cyc = 0;
  logic sclk_prev = 1'b0, lr_prev = 1'b1;
  logic rise, fall, new_left, new_right;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge aud_mclk);
    cyc++;
    rise      = sclk_out & ~sclk_prev;
    fall      = ~sclk_out & sclk_prev;
    new_left  = fall & ~lrclk_out & lr_prev;
    new_right = fall & lrclk_out & ~lr_prev;
    sclk_prev = sclk_out;
    lr_prev   = lrclk_out;
  endtask

  task automatic go_idle();
    enable = 1'b0;
    for (int i = 0; i < 5000 && busy; i++) step();
    check("idle_reached", busy, 0);
  endtask

  task automatic wait_falls(input int n);
    int f = 0;
    for (int i = 0; i < 5000 && f < n; i++) begin
      step();
      if (fall) f++;
    end
    check("fall_wait", f, n);
  endtask

  task automatic measure_period(input string nm, input int exp);
    int r = 0, t0 = 0, t1 = 0;
    for (int i = 0; i < 2000 && r < 2; i++) begin
      step();
      if (rise) begin
        if (r == 0) t0 = cyc; else t1 = cyc;
        r++;
      end
    end
    check(nm, (r == 2) ? t1 - t0 : -1, exp);
  endtask

  // Runs one frame from IDLE and checks timing, data, fetch count and irq.
  task automatic run_vec(input vec_t v);
    logic [64:0] bits, lrs;
    int          rises, rdy, t0, t1, t64;
    logic [23:0] wl, wr;
    logic        extra;
    go_idle();
    sclk_div = v.div; cur_l = v.l; cur_r = v.r; val_l = v.vl; val_r = v.vr;
    irq_clr = 1'b1; step(); irq_clr = 1'b0;
    enable = 1'b1;
    rises = 0; rdy = 0; t0 = 0; t1 = 0; t64 = 0; bits = '0; lrs = '0;
    for (int i = 0; i < 20000 && rises < 65; i++) begin
      step();
      if (rise) begin
        bits[rises] = sdata_0_out;
        lrs[rises]  = lrclk_out;
        if (rises == 0)  t0  = cyc;
        if (rises == 1)  t1  = cyc;
        if (rises == 64) t64 = cyc;
        rises++;
      end
      if (rises >= 1 && rises <= 64 && s_ready) rdy++;
    end
    check({v.name, "_rises"}, rises, 65);
    wl = '0; wr = '0;
    for (int k = 0; k < 24; k++) begin
      wl = {wl[22:0], bits[2 + k]};
      wr = {wr[22:0], bits[34 + k]};
    end
    extra = bits[1] | (|bits[33:26]) | (|bits[64:58]);
    check({v.name, "_period"}, t1 - t0, v.exp_period);
    check({v.name, "_frame"}, t64 - t0, v.exp_frame);
    check({v.name, "_lr_left"}, lrs[1], 0);
    check({v.name, "_lr_right"}, lrs[33], 1);
    check({v.name, "_left"}, wl, v.exp_l);
    check({v.name, "_right"}, wr, v.exp_r);
    check({v.name, "_pad_zero"}, extra, 0);
    check({v.name, "_ready_cnt"}, rdy, 2);
    check({v.name, "_irq"}, underflow_irq, v.exp_irq);
  endtask

  initial begin
    int   f, r;
    logic found;

    vecs[0] = '{"div2", 8'd2, 24'hABCDEF, 24'h123456, 1'b1, 1'b1, 4, 256, 24'hABCDEF, 24'h123456, 1'b0};
    vecs[1] = '{"div0", 8'd0, 24'h800001, 24'h7FFFFE, 1'b1, 1'b1, 2, 128, 24'h800001, 24'h7FFFFE, 1'b0};
    vecs[2] = '{"r_uf", 8'd1, 24'h5A5A5A, 24'hFFFFFF, 1'b1, 1'b0, 2, 128, 24'h5A5A5A, 24'h000000, 1'b1};
    vecs[3] = '{"l_uf", 8'd3, 24'hFFFFFF, 24'h000001, 1'b0, 1'b1, 6, 384, 24'h000000, 24'h000001, 1'b1};
    vecs[4] = '{"ones", 8'd5, 24'hFFFFFF, 24'hFFFFFF, 1'b1, 1'b1, 10, 640, 24'hFFFFFF, 24'hFFFFFF, 1'b0};

    // Reset values, then quiet first cycle after release with enable low.
    step(); step();
    check("rst_sclk", sclk_out, 0);
    check("rst_lrclk", lrclk_out, 1);
    check("rst_sdata", sdata_0_out, 0);
    check("rst_ready", s_ready, 0);
    check("rst_irq", underflow_irq, 0);
    check("rst_busy", busy, 0);
    aud_mrst = 1'b0;
    step();
    check("post_rst_sclk", sclk_out, 0);
    check("post_rst_lrclk", lrclk_out, 1);
    check("post_rst_busy", busy, 0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Underflow: set, clear, then clear coincident with a new underflow.
    go_idle();
    cur_l = 24'h111111; cur_r = 24'h222222; val_l = 1'b1; val_r = 1'b0;
    irq_clr = 1'b1; step(); irq_clr = 1'b0;
    enable = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      step();
      if (s_ready && !lrclk_out) found = 1'b1;
    end
    check("uf_fetch_seen", found, 1);
    step();
    check("uf_set", underflow_irq, 1);
    step(); step();
    check("uf_sticky", underflow_irq, 1);
    irq_clr = 1'b1; step(); irq_clr = 1'b0;
    check("uf_clear", underflow_irq, 0);
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      step();
      if (s_ready && !lrclk_out) found = 1'b1;
    end
    check("uf_second_fetch", found, 1);
    check("uf_still_clear", underflow_irq, 0);
    irq_clr = 1'b1; step(); irq_clr = 1'b0;
    check("uf_set_wins", underflow_irq, 1);

    // Enable dropped at left p=5: right slot finishes, then IDLE.
    go_idle();
    val_l = 1'b1; val_r = 1'b1; sclk_div = 8'd2;
    enable = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      step();
      if (new_left) found = 1'b1;
    end
    check("stop_left_seen", found, 1);
    wait_falls(5);
    enable = 1'b0;
    f = 0; r = 0;
    for (int i = 0; i < 5000 && busy; i++) begin
      step();
      if (fall) f++;
      if (s_ready) r++;
    end
    check("stop_falls", f, 59);
    check("stop_fetches", r, 1);
    check("stop_busy", busy, 0);
    check("stop_sclk", sclk_out, 0);
    check("stop_lrclk", lrclk_out, 1);
    check("stop_sdata", sdata_0_out, 0);
    r = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (s_ready) r++;
    end
    check("stop_no_ready", r, 0);

    // Divider is latched only when leaving IDLE.
    sclk_div = 8'd0;
    enable = 1'b1;
    measure_period("div0_period", 2);
    sclk_div = 8'd4;
    step(); step(); step(); step();
    measure_period("div_change_ignored", 2);
    go_idle();
    enable = 1'b1;
    measure_period("div4_after_idle", 8);

    // Reset at right p=10 forces outputs at once; restart begins with a left slot.
    go_idle();
    sclk_div = 8'd2;
    enable = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      step();
      if (new_right) found = 1'b1;
    end
    check("rst_right_seen", found, 1);
    wait_falls(10);
    aud_mrst = 1'b1;
    #1;
    check("mid_rst_sclk", sclk_out, 0);
    check("mid_rst_lrclk", lrclk_out, 1);
    check("mid_rst_sdata", sdata_0_out, 0);
    check("mid_rst_ready", s_ready, 0);
    check("mid_rst_irq", underflow_irq, 0);
    check("mid_rst_busy", busy, 0);
    enable = 1'b0;
    step(); step();
    aud_mrst = 1'b0;
    step();
    run_vec(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
